// File: rtl/data_access_unit_pkg.sv
// Shared definitions for the data access unit: FSM encoding and bit positions
// within the one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr} extension-type vector.
package data_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int EXT_LB  = 8;
    localparam int EXT_LBU = 7;
    localparam int EXT_LH  = 6;
    localparam int EXT_LHU = 5;
    localparam int EXT_LW  = 4;
    localparam int EXT_LWL = 3;
    localparam int EXT_LWR = 2;
    localparam int EXT_SWL = 1;
    localparam int EXT_SWR = 0;

endpackage

// File: rtl/data_access_unit_load_data_align.sv
// Combinational load extraction: byte/half selection with extension, and the
// lwl/lwr merge of the read word into the old rt value.
module load_data_align
    import data_access_unit_pkg::*;
(
    input  logic [8:0]  ext_type,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [4:0]  sh_off;
    logic [4:0]  sh_left;
    logic [5:0]  sh_keep;
    logic [31:0] rshift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign sh_off  = {off, 3'b000};
    assign sh_left = {~off, 3'b000};
    // 6 bits so that off=3 shifts the keep-mask fully out (rt_old replaced)
    assign sh_keep = {1'b0, sh_off} + 6'd8;
    assign rshift  = rdata >> sh_off;
    assign byte_v  = rshift[7:0];
    assign half_v  = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = '0;
        if (ext_type[EXT_LB])
            result = {{24{byte_v[7]}}, byte_v};
        else if (ext_type[EXT_LBU])
            result = {24'd0, byte_v};
        else if (ext_type[EXT_LH])
            result = {{16{half_v[15]}}, half_v};
        else if (ext_type[EXT_LHU])
            result = {16'd0, half_v};
        else if (ext_type[EXT_LW])
            result = rdata;
        else if (ext_type[EXT_LWL])
            result = (rdata << sh_left) | (rt_old & (32'hFFFF_FFFF >> sh_keep));
        else if (ext_type[EXT_LWR])
            result = rshift | (rt_old & ~(32'hFFFF_FFFF >> sh_off));
        else if (ext_type[EXT_SWL] | ext_type[EXT_SWR])
            result = '0;
    end

endmodule

// File: rtl/data_access_unit.sv
// Memory-stage data bus master: one transaction per load/store, with
// split address/data handshake, flush handling and load result formatting.
module data_access_unit
    import data_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic [8:0]        m_ext_type,
    input  logic [3:0]        m_wen,
    input  logic              m_load,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    input  logic [31:0]       m_rt_old,
    input  logic              m_flush,
    output logic              stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_be,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              rf_valid,
    output logic [31:0]       rf_wdata
);

    state_t      state, state_nxt;
    logic        accept, capture, set_flush, flushed;
    logic        is_load;
    logic [8:0]  ext_q;
    logic [1:0]  off_q;
    logic [31:0] rt_old_q, rdata_q, align_res, placed;

    assign accept = m_valid & (m_load | (|m_wen)) & ~m_flush;
    assign placed = m_ext_type[EXT_SWL] ? (m_wdata >> {~m_addr[1:0], 3'b000})
                                        : (m_wdata << {m_addr[1:0], 3'b000});

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        data_req  = 1'b0;
        rf_valid  = 1'b0;
        capture   = 1'b0;
        set_flush = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                stall     = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                stall    = 1'b1;
                data_req = 1'b1;
                if (data_addr_ok) begin
                    // once the bus owns the request it must be drained
                    set_flush = m_flush;
                    capture   = data_data_ok;
                    state_nxt = data_data_ok ? DONE : WAIT;
                end else if (m_flush) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                stall     = 1'b1;
                set_flush = m_flush;
                if (data_data_ok) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rf_valid  = is_load & ~flushed;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            stall    = 1'b0;
            data_req = 1'b0;
            rf_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            flushed    <= 1'b0;
            is_load    <= 1'b0;
            ext_q      <= '0;
            off_q      <= '0;
            rt_old_q   <= '0;
            rdata_q    <= '0;
            data_wr    <= 1'b0;
            data_be    <= '0;
            data_addr  <= '0;
            data_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                flushed    <= 1'b0;
                is_load    <= m_load;
                ext_q      <= m_ext_type;
                off_q      <= m_addr[1:0];
                rt_old_q   <= m_rt_old;
                data_wr    <= ~m_load;
                data_be    <= m_load ? 4'b1111 : m_wen;
                data_addr  <= {m_addr[ADDR_W-1:2], 2'b00};
                data_wdata <= placed;
            end
            if (set_flush)
                flushed <= 1'b1;
            if (capture)
                rdata_q <= data_rdata;
        end
    end

    load_data_align u_align (
        .ext_type (ext_q),
        .off      (off_q),
        .rdata    (rdata_q),
        .rt_old   (rt_old_q),
        .result   (align_res)
    );

    assign rf_wdata = rf_valid ? align_res : 32'd0;

endmodule

// File: tb/tb_data_access_unit.sv
// Directed table-driven bench for data_access_unit plus hand-written flush and
// mid-transaction reset sequences.
module tb_data_access_unit;

    localparam logic [8:0] LB  = 9'b1_0000_0000;
    localparam logic [8:0] LBU = 9'b0_1000_0000;
    localparam logic [8:0] LH  = 9'b0_0100_0000;
    localparam logic [8:0] LHU = 9'b0_0010_0000;
    localparam logic [8:0] LW  = 9'b0_0001_0000;
    localparam logic [8:0] LWL = 9'b0_0000_1000;
    localparam logic [8:0] LWR = 9'b0_0000_0100;
    localparam logic [8:0] SWL = 9'b0_0000_0010;
    localparam logic [8:0] SWR = 9'b0_0000_0001;
    localparam logic [8:0] ST  = 9'b0_0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_valid = 1'b0;
    logic [8:0]  m_ext_type = '0;
    logic [3:0]  m_wen = '0;
    logic        m_load = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rt_old = '0;
    logic        m_flush = 1'b0;
    logic        stall, data_req, data_wr, rf_valid;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, rf_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_ext_type(m_ext_type),
        .m_wen(m_wen), .m_load(m_load), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rt_old(m_rt_old), .m_flush(m_flush), .stall(stall), .data_req(data_req),
        .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .rf_valid(rf_valid), .rf_wdata(rf_wdata)
    );

    typedef struct {
        string       name;
        logic [8:0]  ext;
        logic [3:0]  wen;
        logic        ld;
        logic [31:0] addr, wdata, rt_old, rdata;
        int          aok_wait, dok_gap;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rfv;
        logic [31:0] e_rf;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [8:0] ext, input logic [3:0] wen,
                                input logic ld, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rt_old, input logic [31:0] rdata,
                                input int aok_wait, input int dok_gap, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic e_rfv, input logic [31:0] e_rf);
        vec_t v;
        v.name = name; v.ext = ext; v.wen = wen; v.ld = ld; v.addr = addr; v.wdata = wdata;
        v.rt_old = rt_old; v.rdata = rdata; v.aok_wait = aok_wait; v.dok_gap = dok_gap;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_rfv = e_rfv; v.e_rf = e_rf;
        return v;
    endfunction

    task automatic drive(input logic [8:0] ext, input logic [3:0] wen, input logic ld,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rt_old);
        m_valid = 1'b1; m_ext_type = ext; m_wen = wen; m_load = ld;
        m_addr = addr; m_wdata = wdata; m_rt_old = rt_old;
    endtask

    // full transaction: accept, aok_wait idle REQ cycles, addr_ok, then data_ok dok_gap cycles later
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.ext, v.wen, v.ld, v.addr, v.wdata, v.rt_old);
        #1 chk({v.name, ".accept_stall"}, {31'd0, stall}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < v.aok_wait; i++) begin
            #1 chk({v.name, ".req_hold"}, {31'd0, data_req}, 32'd1);
            @(negedge clk);
        end
        #1;
        chk({v.name, ".req"}, {31'd0, data_req}, 32'd1);
        chk({v.name, ".addr"}, data_addr, v.addr & 32'hFFFF_FFFC);
        chk({v.name, ".be"}, {28'd0, data_be}, {28'd0, v.e_be});
        chk({v.name, ".wr"}, {31'd0, data_wr}, {31'd0, ~v.ld});
        chk({v.name, ".wdata"}, data_wdata, v.e_wdata);
        data_addr_ok = 1'b1;
        data_data_ok = (v.dok_gap == 0);
        data_rdata   = (v.dok_gap == 0) ? v.rdata : 32'hDEAD_0000;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (v.dok_gap > 0) begin
            for (int i = 1; i < v.dok_gap; i++) begin
                #1;
                chk({v.name, ".wait_req"}, {31'd0, data_req}, 32'd0);
                chk({v.name, ".wait_stall"}, {31'd0, stall}, 32'd1);
                @(negedge clk);
            end
            #1 chk({v.name, ".dok_stall"}, {31'd0, stall}, 32'd1);
            data_data_ok = 1'b1;
            data_rdata   = v.rdata;
            @(negedge clk);
            data_data_ok = 1'b0;
        end
        #1;
        chk({v.name, ".done_stall"}, {31'd0, stall}, 32'd0);
        chk({v.name, ".rf_valid"}, {31'd0, rf_valid}, {31'd0, v.e_rfv});
        if (v.e_rfv) chk({v.name, ".rf_wdata"}, rf_wdata, v.e_rf);
        m_valid = 1'b0;
        @(negedge clk);
        #1;
        chk({v.name, ".idle_stall"}, {31'd0, stall}, 32'd0);
        chk({v.name, ".idle_rfv"}, {31'd0, rf_valid}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
        chk({tag, ".req"}, {31'd0, data_req}, 32'd0);
        chk({tag, ".wr"}, {31'd0, data_wr}, 32'd0);
        chk({tag, ".be"}, {28'd0, data_be}, 32'd0);
        chk({tag, ".addr"}, data_addr, 32'd0);
        chk({tag, ".wdata"}, data_wdata, 32'd0);
        chk({tag, ".rfv"}, {31'd0, rf_valid}, 32'd0);
        chk({tag, ".rfw"}, rf_wdata, 32'd0);
    endtask

    initial begin
        vecs[0]  = mk("lb_1003",  LB,  4'b0000, 1, 32'h1003, 0, 0, 32'h80FF_0000, 0, 2, 4'hF, 0, 1, 32'hFFFF_FF80);
        vecs[1]  = mk("sb_2002",  ST,  4'b0100, 0, 32'h2002, 32'h0000_00AB, 0, 0, 0, 0, 4'b0100, 32'h00AB_0000, 0, 0);
        vecs[2]  = mk("lwl_off1", LWL, 4'b0000, 1, 32'h3001, 0, 32'hAABB_CCDD, 32'h1122_3344, 1, 1, 4'hF, 0, 1, 32'h3344_CCDD);
        vecs[3]  = mk("lwr_off1", LWR, 4'b0000, 1, 32'h3001, 0, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 4'hF, 0, 1, 32'hAA11_2233);
        vecs[4]  = mk("lbu_1003", LBU, 4'b0000, 1, 32'h1003, 0, 0, 32'h80FF_0000, 2, 1, 4'hF, 0, 1, 32'h0000_0080);
        vecs[5]  = mk("lh_4002",  LH,  4'b0000, 1, 32'h4002, 0, 0, 32'h8001_1234, 0, 1, 4'hF, 0, 1, 32'hFFFF_8001);
        vecs[6]  = mk("lhu_4000", LHU, 4'b0000, 1, 32'h4000, 0, 0, 32'h8001_F234, 0, 3, 4'hF, 0, 1, 32'h0000_F234);
        vecs[7]  = mk("lw_5004",  LW,  4'b0000, 1, 32'h5004, 0, 0, 32'hDEAD_BEEF, 0, 0, 4'hF, 0, 1, 32'hDEAD_BEEF);
        vecs[8]  = mk("lwl_off3", LWL, 4'b0000, 1, 32'h3003, 0, 32'hAABB_CCDD, 32'h1122_3344, 0, 1, 4'hF, 0, 1, 32'h1122_3344);
        vecs[9]  = mk("lwr_off3", LWR, 4'b0000, 1, 32'h3003, 0, 32'hAABB_CCDD, 32'h1122_3344, 0, 1, 4'hF, 0, 1, 32'hAABB_CC11);
        vecs[10] = mk("lwl_off0", LWL, 4'b0000, 1, 32'h3000, 0, 32'hAABB_CCDD, 32'h1122_3344, 0, 1, 4'hF, 0, 1, 32'h44BB_CCDD);
        vecs[11] = mk("swl_off1", SWL, 4'b0011, 0, 32'h6001, 32'h1122_3344, 0, 0, 0, 1, 4'b0011, 32'h0000_1122, 0, 0);
        vecs[12] = mk("swr_off2", SWR, 4'b1100, 0, 32'h6002, 32'h1122_3344, 0, 0, 1, 0, 4'b1100, 32'h3344_0000, 0, 0);
        vecs[13] = mk("sw_7000",  ST,  4'b1111, 0, 32'h7000, 32'hCAFE_BABE, 0, 0, 0, 2, 4'b1111, 32'hCAFE_BABE, 0, 0);

        // reset state, with a valid load presented during reset
        drive(LW, 4'b0000, 1, 32'h1234, 0, 0);
        #12 chk_zero("reset");
        m_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // flush in REQ before addr_ok: request dropped, and flush still high blocks re-accept
        @(negedge clk);
        drive(LW, 4'b0000, 1, 32'h8000, 0, 0);
        @(negedge clk);
        m_flush = 1'b1;
        #1 chk("flreq.req_before", {31'd0, data_req}, 32'd1);
        @(negedge clk);
        #1;
        chk("flreq.req_dropped", {31'd0, data_req}, 32'd0);
        chk("flreq.idle_stall", {31'd0, stall}, 32'd0);
        chk("flreq.rfv", {31'd0, rf_valid}, 32'd0);
        m_valid = 1'b0;
        m_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("flreq.no_rfv", {31'd0, rf_valid | data_req | stall}, 32'd0);
        end

        // flush pulse during WAIT: drain until data_ok, then no rf_valid
        @(negedge clk);
        drive(LW, 4'b0000, 1, 32'h8004, 0, 0);
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        m_flush = 1'b1;
        #1 chk("flwait.stall0", {31'd0, stall}, 32'd1);
        @(negedge clk);
        m_flush = 1'b0;
        m_valid = 1'b0;
        #1 chk("flwait.stall1", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1 chk("flwait.stall2", {31'd0, stall}, 32'd1);
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_AAAA;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        chk("flwait.done_stall", {31'd0, stall}, 32'd0);
        chk("flwait.rfv", {31'd0, rf_valid}, 32'd0);
        @(negedge clk);

        // reset asserted mid-WAIT: outputs clear with no clock edge
        drive(LW, 4'b0000, 1, 32'h9008, 0, 0);
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1 chk("rstwait.in_wait", {31'd0, stall}, 32'd1);
        #2 reset = 1'b1;
        #1 chk_zero("rstwait");
        m_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[7]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

endmodule

// File: doc/data_access_unit.md
DATA_ACCESS_UNIT -- requirements
Module: data_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32: data bus address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m_valid  input  1  memory-stage instruction present.
REQ-005 m_ext_type  input  9  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr} from memory control decode.
REQ-006 m_wen  input  4  store byte enables; all zero for non-store.
REQ-007 m_load  input  1  instruction is a load-family op.
REQ-008 m_addr  input  ADDR_W  effective address, not yet aligned.
REQ-009 m_wdata  input  32  raw rt store value.
REQ-010 m_rt_old  input  32  current rt value, used for lwl/lwr merge.
REQ-011 m_flush  input  1  exception/cancel for the memory-stage instruction.
REQ-012 stall  output  1  hold the pipeline.
REQ-013 data_req, data_wr  output  1 each  bus request; 1 = write.
REQ-014 data_be  output  4  byte enables.
REQ-015 data_addr  output  ADDR_W  word-aligned address, low 2 bits zero.
REQ-016 data_wdata  output  32  lane-placed store data.
REQ-017 data_addr_ok, data_data_ok  input  1 each  request accepted; response or write complete.
REQ-018 data_rdata  input  32  read word.
REQ-019 rf_valid  output  1  one-cycle pulse: load result valid.
REQ-020 rf_wdata  output  32  extended or merged load result.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-022 IDLE: accept when m_valid & (m_load | m_wen!=0) & !m_flush; latch address, byte enables, type, lane-placed data and rt_old; go to REQ.
REQ-023 Store lane placement: swl -> m_wdata >> 8*(3-off); all other stores -> m_wdata << 8*off (off = m_addr[1:0]).
REQ-024 Loads: data_be = 4'b1111, data_wr = 0; stores: data_be = latched m_wen, data_wr = 1.
REQ-025 REQ: data_req = 1 with stable outputs until data_addr_ok.
- addr_ok alone -> WAIT.
- addr_ok & data_ok in the same cycle -> DONE.
REQ-026 WAIT: data_req = 0; on data_data_ok capture data_rdata -> DONE.
REQ-027 DONE: rf_valid = 1 for loads only, stall = 0; unconditionally return to IDLE without re-accepting the held instruction.
REQ-028 stall = (IDLE & accept condition) | REQ | WAIT; stall = 0 in DONE.
REQ-029 Load extraction on the captured word r:
- lb/lbu: byte r[8*off+:8], sign- or zero-extended.
- lh/lhu: r[16*off[1]+:16], sign- or zero-extended.
- lw: r.
REQ-030 lwl result = (r << 8*(3-off)) | (rt_old & (32'hFFFFFFFF >> 8*(off+1))); for off=3, rt_old is fully replaced.
REQ-031 lwr result = (r >> 8*off) | (rt_old & ~(32'hFFFFFFFF >> 8*off)).
REQ-032 m_flush in REQ before addr_ok: drop the request and go to IDLE; no rf_valid.
REQ-033 m_flush after addr_ok: drain in WAIT until data_ok; rf_valid suppressed (flush remembered in a sticky bit).
REQ-034 m_flush in IDLE blocks acceptance; stall = 0.

Reset
REQ-035 Reset SHALL force state IDLE, sticky flush bit 0 and every output 0, immediately and asynchronously, including mid-transaction; the outstanding bus transaction is abandoned.

Structure
REQ-036 Shared package SHALL hold the FSM state encoding and the ExtType bit-index constants.
REQ-037 The combinational extract/merge logic SHALL be sub-module load_data_align; the FSM and lane placement stay in the top.

Verification
REQ-038 lb at 0x1003, addr_ok cycle 1, data_ok cycle 3, rdata 0x80FF_0000 -> data_addr 0x1000; stall cycles 0-3; DONE cycle 4 with rf_valid = 1 and rf_wdata 0xFFFF_FF80.
REQ-039 sb at 0x2002, rt 0x0000_00AB, addr_ok and data_ok same cycle -> data_be 0100, data_wdata 0x00AB_0000, REQ->DONE directly, rf_valid = 0.
REQ-040 lwl at offset 1, r 0x1122_3344, rt_old 0xAABB_CCDD -> rf_wdata 0x3344_CCDD; lwr at offset 1, same inputs -> 0xAA11_2233.
REQ-041 Flush in REQ before addr_ok -> data_req drops next cycle, IDLE, no rf_valid; flush during WAIT -> stall held until data_ok, rf_valid = 0.
REQ-042 Reset asserted in WAIT -> outputs 0 and state IDLE without a clock edge; a later load completes normally.
